// File: rtl/i2c_slave_regs.sv
// I2C target bridging SCL/SDA traffic to an 8-bit register bus with an auto-incrementing pointer.
// Latency: scl/sda pass a 2-FF synchroniser plus history stage, so bus events act 2-3 clk late.
// Backpressure: none; the target never stretches SCL, so clk must run at least 10x SCL.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   scl               I2C clock from the master
//   sda               I2C data, open-drain: pulled low only while sda_oe_q is set
//   reg_addr          register pointer, also the write/read address
//   reg_wdata         write data, valid while reg_wr_en is high
//   reg_wr_en         one-clk write strobe
//   reg_rdata         combinational read data for reg_addr
//   busy              high from START until STOP
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         PTR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    inout  wire              sda,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_wr_en,
    input  logic [7:0]       reg_rdata,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    // Synchronisers and history stage.
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    state_t           state_q,  state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q,  shift_d;
    logic [PTR_W-1:0] ptr_q,    ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             wr_en_q,  wr_en_d;
    logic [7:0]       wdata_q,  wdata_d;
    logic             busy_q,   busy_d;
    logic             first_q,  first_d;
    logic             rw_q,     rw_d;

    logic [7:0]       rx_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s &  scl_hist_q;
    // Data may only change while SCL is low; a change while SCL is high marks START/STOP.
    assign start_det =  scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  =  scl_s & scl_hist_q & ~sda_hist_q &  sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus level is high, so resetting to 1 avoids phantom edges.
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            first_q   <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            first_q   <= first_d;
            rw_q      <= rw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        first_d   = first_q;
        rw_d      = rw_q;

        // Pointer advances the clk after a write strobe so the strobe sees the old address.
        if (wr_en_q) begin
            ptr_d = ptr_q + PTR_W'(1);
        end

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
            first_d   = 1'b1;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            // Open-drain: a 1 bit is sent by releasing the line.
                            shift_d   = {reg_rdata[6:0], 1'b0};
                            sda_oe_d  = ~reg_rdata[7];
                            bit_cnt_d = 4'd1;
                            state_d   = RD_BYTE;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (first_q) begin
                                ptr_d   = PTR_W'(rx_byte);
                                first_d = 1'b0;
                            end else begin
                                wr_en_d = 1'b1;
                                wdata_d = rx_byte;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = WR_ACK;
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = WR_BYTE;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q != 4'd8) begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                            ptr_d    = ptr_q + PTR_W'(1);
                        end
                    end
                end
                RD_ACK: begin
                    // RD_ACK is entered on a fall, so the next fall follows the ack rise.
                    if (scl_rise && sda_s) begin
                        state_d = IGNORE;
                    end else if (scl_fall) begin
                        shift_d   = {reg_rdata[6:0], 1'b0};
                        sda_oe_d  = ~reg_rdata[7];
                        bit_cnt_d = 4'd1;
                        state_d   = RD_BYTE;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master drives scl/sda,
// register writes and read bytes are checked against scoreboard queues.
// Register file model: reg_rdata = 0x20 + reg_addr.
module tb_i2c_slave_regs;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic [7:0] reg_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic        quiet_watch = 1'b0;
    int          quiet_low   = 0;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    assign reg_rdata = 8'h20 + reg_addr;

    always #5 clk = ~clk;

    i2c_slave_regs #(.SLAVE_ADDR(7'h50), .PTR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-strobe scoreboard and "target stays silent" watcher.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (wr_q.size() > 0) begin
                check("wr_strobe", {reg_addr, reg_wdata}, wr_q.pop_front());
            end else begin
                check("wr_unexpected", 16'(reg_wr_en), 16'd0);
            end
        end
        if (quiet_watch && !m_sda_low && sda !== 1'b1) begin
            quiet_low++;
        end
    end

    task automatic i2c_start();
        m_sda_low = 1'b0; #T;
        scl = 1'b1;       #T;
        m_sda_low = 1'b1; #T;
        scl = 1'b0;       #T;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #T;
        scl = 1'b1;       #T;
        m_sda_low = 1'b0; #T;
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; #T;
        scl = 1'b1;     #(2*T);
        scl = 1'b0;     #T;
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0; #T;
        scl = 1'b1;       #T;
        b = sda;          #T;
        scl = 1'b0;       #T;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        int         q0;

        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_addr",  16'(reg_addr),  16'h00);
        check("rst_wdata", 16'(reg_wdata), 16'h00);
        check("rst_wr_en", 16'(reg_wr_en), 16'h0);
        check("rst_busy",  16'(busy),      16'h0);
        check("rst_sda",   16'(sda),       16'h1);

        // 1: single write
        i2c_start();
        write_byte(8'hA0, ack); check("t1_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h10, ack); check("t1_ptr_ack",  16'(ack), 16'h0);
        wr_q.push_back({8'h10, 8'hA5});
        write_byte(8'hA5, ack); check("t1_data_ack", 16'(ack), 16'h0);
        check("t1_busy", 16'(busy), 16'h1);
        i2c_stop();
        check("t1_busy_end", 16'(busy),        16'h0);
        check("t1_ptr",      16'(reg_addr),    16'h11);
        check("t1_wr_left",  16'(wr_q.size()), 16'd0);

        // 2: burst write across pointer wrap
        i2c_start();
        write_byte(8'hA0, ack); check("t2_addr_ack", 16'(ack), 16'h0);
        write_byte(8'hFE, ack); check("t2_ptr_ack",  16'(ack), 16'h0);
        wr_q.push_back({8'hFE, 8'h01});
        write_byte(8'h01, ack); check("t2_d0_ack", 16'(ack), 16'h0);
        wr_q.push_back({8'hFF, 8'h02});
        write_byte(8'h02, ack); check("t2_d1_ack", 16'(ack), 16'h0);
        wr_q.push_back({8'h00, 8'h03});
        write_byte(8'h03, ack); check("t2_d2_ack", 16'(ack), 16'h0);
        i2c_stop();
        check("t2_ptr",     16'(reg_addr),    16'h01);
        check("t2_wr_left", 16'(wr_q.size()), 16'd0);

        // 3: set pointer, repeated START, read two bytes
        i2c_start();
        write_byte(8'hA0, ack); check("t3_waddr_ack", 16'(ack), 16'h0);
        write_byte(8'h20, ack); check("t3_ptr_ack",   16'(ack), 16'h0);
        i2c_start();
        write_byte(8'hA1, ack); check("t3_raddr_ack", 16'(ack), 16'h0);
        rd_q.push_back(8'h40);
        read_byte(d, 1'b0); check("t3_rd0", 16'(d), 16'(rd_q.pop_front()));
        rd_q.push_back(8'h41);
        read_byte(d, 1'b1); check("t3_rd1", 16'(d), 16'(rd_q.pop_front()));
        check("t3_release", 16'(sda), 16'h1);
        i2c_stop();
        check("t3_ptr", 16'(reg_addr), 16'h22);

        // 4: wrong address must be ignored
        q0 = quiet_low;
        quiet_watch = 1'b1;
        i2c_start();
        write_byte(8'hA2, ack); check("t4_addr_nack", 16'(ack), 16'h1);
        write_byte(8'h33, ack); check("t4_data_nack", 16'(ack), 16'h1);
        i2c_stop();
        quiet_watch = 1'b0;
        check("t4_sda_quiet", 16'(quiet_low - q0), 16'd0);
        check("t4_ptr",       16'(reg_addr),       16'h22);
        check("t4_wr_left",   16'(wr_q.size()),    16'd0);

        // 5: STOP after 4 bits of a data byte, then a normal write
        i2c_start();
        write_byte(8'hA0, ack); check("t5_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h30, ack); check("t5_ptr_ack",  16'(ack), 16'h0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("t5_busy_abort", 16'(busy),     16'h0);
        check("t5_ptr_abort",  16'(reg_addr), 16'h30);
        i2c_start();
        write_byte(8'hA0, ack); check("t5b_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h40, ack); check("t5b_ptr_ack",  16'(ack), 16'h0);
        wr_q.push_back({8'h40, 8'h77});
        write_byte(8'h77, ack); check("t5b_data_ack", 16'(ack), 16'h0);
        i2c_stop();
        check("t5b_ptr",     16'(reg_addr),    16'h41);
        check("t5b_wr_left", 16'(wr_q.size()), 16'd0);

        // 6: reset while the target is driving a read bit (0xA0: bit7=1, bit6=0)
        i2c_start();
        write_byte(8'hA0, ack); check("t6_waddr_ack", 16'(ack), 16'h0);
        write_byte(8'h80, ack); check("t6_ptr_ack",   16'(ack), 16'h0);
        i2c_start();
        write_byte(8'hA1, ack); check("t6_raddr_ack", 16'(ack), 16'h0);
        recv_bit(b); check("t6_bit7", 16'(b), 16'h1);
        @(negedge clk);
        check("t6_driving", 16'(sda), 16'h0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_sda",   16'(sda),       16'h1);
        check("t6_rst_addr",  16'(reg_addr),  16'h00);
        check("t6_rst_wdata", 16'(reg_wdata), 16'h00);
        check("t6_rst_wr_en", 16'(reg_wr_en), 16'h0);
        check("t6_rst_busy",  16'(busy),      16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Clocking on without a START must not wake the target.
        q0 = quiet_low;
        quiet_watch = 1'b1;
        for (int i = 0; i < 9; i++) recv_bit(b);
        quiet_watch = 1'b0;
        check("t6_idle_quiet", 16'(quiet_low - q0), 16'd0);
        check("t6_idle_busy",  16'(busy),           16'h0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack); check("t6b_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h05, ack); check("t6b_ptr_ack",  16'(ack), 16'h0);
        wr_q.push_back({8'h05, 8'h11});
        write_byte(8'h11, ack); check("t6b_data_ack", 16'(ack), 16'h0);
        i2c_stop();
        check("t6b_ptr",     16'(reg_addr),    16'h06);
        check("t6b_wr_left", 16'(wr_q.size()), 16'd0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
